// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-setting controller: state encoding,
// field limits and widths, and the snooze time-add helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_RING    = 2'd3
  } alarm_state_e;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned CNT_W = 8;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // Adds a minute offset (< 60) to hh:mm, carrying into the hour and wrapping past 23:59.
  function automatic logic [HR_W+MIN_W-1:0] add_minutes(
    input logic [HR_W-1:0]  hr,
    input logic [MIN_W-1:0] mn,
    input logic [MIN_W-1:0] add
  );
    logic [MIN_W:0]  sum;
    logic [HR_W-1:0] h;
    sum = {1'b0, mn} + {1'b0, add};
    h   = hr;
    if (sum > {1'b0, MIN_MAX}) begin
      sum = sum - 7'd60;
      h   = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
    end else begin
      h   = hr;
    end
    return {h, sum[MIN_W-1:0]};
  endfunction

endpackage

// File: rtl/wrap_field_ctr.sv
// Up/down counter for a time field that wraps between 0 and MAX in both
// directions; increment wins when both steps are requested.
module wrap_field_ctr #(
  parameter int unsigned    W   = 5,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next field value with wrap at both ends.
  always_comb begin
    val_d = val_q;
    if (inc) begin
      val_d = (val_q == MAX) ? '0 : val_q + W'(1);
    end else if (dec) begin
      val_d = (val_q == '0) ? MAX : val_q - W'(1);
    end else begin
      val_d = val_q;
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm set/ring controller: edits alarm hh:mm from debounced presses, arms the
// alarm and rings on a time match. Snooze is built only with ALARM_SNOOZE_EN.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned RING_MAX_S = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_p,
  input  logic             inc_p,
  input  logic             dec_p,
  input  logic             sec_tick,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic [HR_W-1:0]  alarm_hr,
  output logic [MIN_W-1:0] alarm_min,
  output logic             alarm_on,
  output logic             ringing,
  output logic             edit_hr,
  output logic             edit_min
);

  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_S);
  localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_MAX_S);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             on_q, on_d;
  logic             match_q, match_s;
  logic             ring_trig_s;
  logic             press_s;
  logic             hr_inc_s, hr_dec_s, min_inc_s, min_dec_s;
  logic [HR_W-1:0]  alarm_hr_s;
  logic [MIN_W-1:0] alarm_min_s;

  wrap_field_ctr #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (hr_inc_s),
    .dec   (hr_dec_s),
    .val   (alarm_hr_s)
  );

  wrap_field_ctr #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst),
    .inc   (min_inc_s),
    .dec   (min_dec_s),
    .val   (alarm_min_s)
  );

  assign press_s   = mode_p | inc_p | dec_p;
  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign match_s   = on_q & (cur_hr == alarm_hr_s) & (cur_min == alarm_min_s);

  // Field steps only in their edit state; mode_p masks inc_p/dec_p, inc_p masks dec_p.
  always_comb begin
    hr_inc_s  = (state_q == ST_SET_HR)  & ~mode_p & inc_p;
    hr_dec_s  = (state_q == ST_SET_HR)  & ~mode_p & ~inc_p & dec_p;
    min_inc_s = (state_q == ST_SET_MIN) & ~mode_p & inc_p;
    min_dec_s = (state_q == ST_SET_MIN) & ~mode_p & ~inc_p & dec_p;
  end

`ifdef ALARM_SNOOZE_EN
  localparam logic [MIN_W-1:0] SNZ_ADD = MIN_W'(SNOOZE_MIN);

  logic [HR_W-1:0]  snz_hr_q, snz_hr_d;
  logic [MIN_W-1:0] snz_min_q, snz_min_d;
  logic             snz_armed_q, snz_armed_d;
  logic             snz_match_q, snz_match_s;

  assign snz_match_s = snz_armed_q & (cur_hr == snz_hr_q) & (cur_min == snz_min_q);
  assign ring_trig_s = (match_s & ~match_q) | (snz_match_s & ~snz_match_q);
`else
  assign ring_trig_s = match_s & ~match_q;
`endif

  // Next-state, counter and arm-flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
`ifdef ALARM_SNOOZE_EN
    snz_hr_d    = snz_hr_q;
    snz_min_d   = snz_min_q;
    snz_armed_d = snz_armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mode_p) begin
          state_d = ST_SET_HR;
        end else if (inc_p) begin
          on_d = ~on_q;
`ifdef ALARM_SNOOZE_EN
          if (on_q) begin
            snz_armed_d = 1'b0;
          end else begin
            snz_armed_d = snz_armed_q;
          end
`endif
        end else if (ring_trig_s) begin
          state_d = ST_RING;
`ifdef ALARM_SNOOZE_EN
          snz_armed_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        if (mode_p) begin
          state_d = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_IDLE;
          cnt_d   = '0;
        end else if (press_s) begin
          cnt_d = '0;
        end else if (sec_tick) begin
          if (cnt_inc_s == TO_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RING: begin
        if (press_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
          if (!mode_p && inc_p) begin
            {snz_hr_d, snz_min_d} = add_minutes(cur_hr, cur_min, SNZ_ADD);
            snz_armed_d = 1'b1;
          end else begin
            snz_armed_d = 1'b0;
          end
`endif
        end else if (sec_tick) begin
          if (cnt_inc_s == RING_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      on_q    <= 1'b0;
      match_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_hr_q    <= '0;
      snz_min_q   <= '0;
      snz_armed_q <= 1'b0;
      snz_match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      match_q <= match_s;
`ifdef ALARM_SNOOZE_EN
      snz_hr_q    <= snz_hr_d;
      snz_min_q   <= snz_min_d;
      snz_armed_q <= snz_armed_d;
      snz_match_q <= snz_match_s;
`endif
    end
  end

  assign alarm_hr  = alarm_hr_s;
  assign alarm_min = alarm_min_s;
  assign alarm_on  = on_q;
  assign ringing   = (state_q == ST_RING);
  assign edit_hr   = (state_q == ST_SET_HR);
  assign edit_min  = (state_q == ST_SET_MIN);

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl (default build): directed test-plan scenarios, then
// randomized presses/ticks/time checked every cycle against a behavioural model.
module tb_alarm_set_ctrl;

  localparam int TO_S   = 10;
  localparam int RMAX_S = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0, sec_tick = 1'b0;
  logic [4:0] cur_hr = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_on, ringing, edit_hr, edit_min;

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 idle, 1 editing hour, 2 editing minute, 3 ringing.
  int m_st, m_hr, m_min, m_on, m_cnt, m_prev;

  alarm_set_ctrl #(.TIMEOUT_S(TO_S), .RING_MAX_S(RMAX_S), .SNOOZE_MIN(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_p    (mode_p),
    .inc_p     (inc_p),
    .dec_p     (dec_p),
    .sec_tick  (sec_tick),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .alarm_on  (alarm_on),
    .ringing   (ringing),
    .edit_hr   (edit_hr),
    .edit_min  (edit_min)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {17'd0, ringing, edit_hr, edit_min, alarm_on, alarm_hr, alarm_min};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = 32'd0;
    v[14]   = (m_st == 3);
    v[13]   = (m_st == 1);
    v[12]   = (m_st == 2);
    v[11]   = (m_on != 0);
    v[10:6] = m_hr[4:0];
    v[5:0]  = m_min[5:0];
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_hr = 0; m_min = 0; m_on = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit md, input bit ic, input bit dc, input bit tk,
                            input int ch, input int cm);
    bit m, trig;
    m      = (m_on != 0) && (ch == m_hr) && (cm == m_min);
    trig   = m && (m_prev == 0);
    m_prev = m ? 1 : 0;
    if (m_st == 0) begin
      if (md) begin m_st = 1; m_cnt = 0; end
      else if (ic) m_on = (m_on != 0) ? 0 : 1;
      else if (trig) begin m_st = 3; m_cnt = 0; end
    end else if (m_st == 1 || m_st == 2) begin
      if (md) begin m_st = (m_st == 1) ? 2 : 0; m_cnt = 0; end
      else if (ic || dc) begin
        m_cnt = 0;
        if (m_st == 1) m_hr  = ic ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        else           m_min = ic ? (m_min + 1) % 60 : (m_min + 59) % 60;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == TO_S) begin m_st = 0; m_cnt = 0; end
      end
    end else begin
      if (md || ic || dc) begin m_st = 0; m_cnt = 0; end
      else if (tk) begin
        m_cnt++;
        if (m_cnt == RMAX_S) begin m_st = 0; m_cnt = 0; end
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic cyc(input bit md, input bit ic, input bit dc, input bit tk,
                     input int ch, input int cm);
    mode_p = md; inc_p = ic; dec_p = dc; sec_tick = tk;
    cur_hr = ch[4:0]; cur_min = cm[5:0];
    @(posedge clk);
    model_step(md, ic, dc, tk, ch, cm);
    #1;
    check_val("outs", dut_vec(), model_vec());
  endtask

  initial begin
    int den, r, ch, cm;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", dut_vec(), 32'd0);
    rst = 1'b1;

    // Set 05:57 through the edit sequence.
    cyc(1, 0, 0, 0, 12, 0);
    repeat (5) cyc(0, 1, 0, 0, 12, 0);
    cyc(1, 0, 0, 0, 12, 0);
    repeat (3) cyc(0, 0, 1, 0, 12, 0);
    cyc(1, 0, 0, 0, 12, 0);
    check_val("t1_hr", 32'(alarm_hr), 32'd5);
    check_val("t1_min", 32'(alarm_min), 32'd57);
    check_val("t1_edit", {30'd0, edit_hr, edit_min}, 32'd0);

    // Arm, set 06:30, ring on the match edge, auto-dismiss after 60 ticks.
    cyc(0, 1, 0, 0, 12, 0);
    check_val("t2_on", 32'(alarm_on), 32'd1);
    cyc(1, 0, 0, 0, 12, 0);
    cyc(0, 1, 0, 0, 12, 0);
    cyc(1, 0, 0, 0, 12, 0);
    repeat (27) cyc(0, 0, 1, 0, 12, 0);
    cyc(1, 0, 0, 0, 12, 0);
    check_val("t2_set", {24'd0, 3'd0, alarm_hr} * 32'd100 + 32'(alarm_min), 32'd630);
    cyc(0, 0, 0, 0, 6, 29);
    check_val("t2_quiet", 32'(ringing), 32'd0);
    cyc(0, 0, 0, 0, 6, 30);
    check_val("t2_ring", 32'(ringing), 32'd1);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 0, 1, 6, 30);
      if (i == 58) check_val("t2_ring_59", 32'(ringing), 32'd1);
    end
    check_val("t2_ring_end", 32'(ringing), 32'd0);
    check_val("t2_on_kept", 32'(alarm_on), 32'd1);

    // Edit timeout in SET_MIN, restarted by a press on tick 9.
    cyc(1, 0, 0, 0, 6, 30);
    cyc(1, 0, 0, 0, 6, 30);
    cyc(0, 1, 0, 0, 6, 30);
    repeat (8) cyc(0, 0, 0, 1, 6, 30);
    cyc(0, 1, 0, 1, 6, 30);
    repeat (9) cyc(0, 0, 0, 1, 6, 30);
    check_val("t3_still_edit", 32'(edit_min), 32'd1);
    cyc(0, 0, 0, 1, 6, 30);
    check_val("t3_timeout", {30'd0, edit_hr, edit_min}, 32'd0);
    check_val("t3_min_kept", 32'(alarm_min), 32'd32);

    // mode_p beats inc_p in SET_HR.
    cyc(1, 0, 0, 0, 6, 30);
    cyc(1, 1, 0, 0, 6, 30);
    check_val("t4_setmin", 32'(edit_min), 32'd1);
    check_val("t4_hr", 32'(alarm_hr), 32'd6);
    cyc(1, 0, 0, 0, 6, 30);

    // Ring at 06:32, then async reset mid-ring.
    cyc(0, 0, 0, 0, 6, 31);
    cyc(0, 0, 0, 0, 6, 32);
    check_val("t6_ring", 32'(ringing), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("t6_rst_ring", 32'(ringing), 32'd0);
    check_val("t6_rst_outs", dut_vec(), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized phase: alternating busy and quiet blocks.
    for (int b = 0; b < 8; b++) begin
      den = (b % 2 == 0) ? 25 : 400;
      for (int k = 0; k < 500; k++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          ch = m_hr; cm = m_min;
        end else if (r == 1) begin
          ch = (m_min == 0) ? (m_hr + 23) % 24 : m_hr;
          cm = (m_min + 59) % 60;
        end else begin
          ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
        end
        cyc(($urandom % den) == 0, ($urandom % den) == 0, ($urandom % den) == 0,
            (b % 2 == 1) || ($urandom % 3 == 0), ch, cm);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
